// File: rtl/home_pkg.sv
// home_pkg: shared display codes, ASCII prefix and transmitter state type
package home_pkg;
  localparam logic [2:0] DISP_START = 3'd0;
  localparam logic [2:0] DISP_FRONT_DOOR = 3'd1;
  localparam logic [2:0] DISP_REAR_DOOR = 3'd2;
  localparam logic [2:0] DISP_FIRE_ALARM = 3'd3;
  localparam logic [2:0] DISP_WINDOW = 3'd4;
  localparam logic [2:0] DISP_HEATER = 3'd5;
  localparam logic [2:0] DISP_COOLER = 3'd6;
  localparam logic [4:0] ASCII_DIGIT_HI = 5'b00110;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/home_status_fifo.sv
// home_status_fifo: small synchronous FIFO, push accepted when full if a pop shares the edge
module home_status_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  // storage write, no reset needed since count gates every read
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  // pointers and occupancy
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/home_status_tx.sv
// home_status_tx: queue every display change and send it as an 8N1 ASCII digit
module home_status_tx import home_pkg::*; #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic [2:0]                          display,
  output logic                                tx,
  output logic                                busy,
  output logic                                overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  tx_state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_cnt, bit_n, last_code, dout;
  logic [7:0] shreg, shreg_n;
  logic push, pop, full, empty, tx_n, baud_end;
  assign push = display != last_code;
  assign baud_end = baud == BW'(CLKS_PER_BIT-1);
  home_status_fifo #(.WIDTH(3), .DEPTH(FIFO_DEPTH)) u_fifo (
    .Clk(Clk), .Rst(Rst), .push(push), .pop(pop), .din(display),
    .dout(dout), .full(full), .empty(empty), .count(fifo_count)
  );
  // next-state, next line level and pop decision
  always_comb begin
    state_n = state;
    baud_n = baud_end ? '0 : baud + 1'b1;
    bit_n = bit_cnt;
    shreg_n = shreg;
    tx_n = tx;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop = 1'b1;
          shreg_n = {ASCII_DIGIT_HI, dout};
          state_n = START;
          tx_n = 1'b0;
        end
      end
      START: if (baud_end) begin
        state_n = DATA;
        bit_n = '0;
        tx_n = shreg[0];
      end
      DATA: if (baud_end) begin
        shreg_n = shreg >> 1;
        bit_n = bit_cnt + 1'b1;
        tx_n = bit_cnt == 3'd7 ? 1'b1 : shreg[1];
        state_n = bit_cnt == 3'd7 ? STOP : DATA;
      end
      STOP: if (baud_end) begin
        pop = !empty;
        state_n = empty ? IDLE : START;
        tx_n = empty;
        shreg_n = empty ? shreg : {ASCII_DIGIT_HI, dout};
      end
      default: state_n = IDLE;
    endcase
  end
  // registered state, line and status; last_code tracks display even when a push is dropped
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      overflow <= 1'b0;
      last_code <= DISP_START;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shreg <= shreg_n;
      tx <= tx_n;
      busy <= state_n != IDLE;
      overflow <= overflow | (push & full & ~pop);
      last_code <= display;
    end
  end
endmodule
